// File: rtl/online_ccm_sched_pkg.sv
// Shared types and constants for the online CCM scheduler slice.
// Signed-digit encodings, FSM state type and the digits-to-bits width helper.
package online_ccm_sched_pkg;

    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_t;

    // Each SD digit occupies two bits, {plus, minus}.
    function automatic int sd_bits(input int n_digits);
        return 2 * n_digits;
    endfunction

endpackage

// File: rtl/online_ccm_sched_if.sv
// Requester, datapath and result signals of the online CCM scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface online_ccm_sched_if #(
    parameter int STAGE = 4
);
    import online_ccm_sched_pkg::*;

    logic                            req0_valid;
    logic [sd_bits(STAGE)-1:0]       req0_data;
    logic                            req0_ready;
    logic                            req1_valid;
    logic [sd_bits(STAGE)-1:0]       req1_data;
    logic                            req1_ready;
    logic                            dp_en;
    logic                            dp_first;
    logic [1:0]                      dp_x;
    logic [1:0]                      dp_z;
    logic                            res_valid;
    logic [sd_bits(STAGE+2)-1:0]     res_data;
    logic                            res_id;
    logic                            res_ready;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, dp_z, res_ready,
        output req0_ready, req1_ready, dp_en, dp_first, dp_x,
               res_valid, res_data, res_id
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, dp_z, res_ready,
        input  req0_ready, req1_ready, dp_en, dp_first, dp_x,
               res_valid, res_data, res_id
    );

endinterface

// File: rtl/online_rr_arb2.sv
// Two-way round-robin grant; the requester that did not win last time has priority.
// last_grant only moves when the grant is actually accepted.
module online_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant
);

    logic last_grant;

    always_comb begin
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else begin
            grant = valid1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/online_ccm_sched.sv
// Shares one digit-serial online multiply-by-3 datapath between two requesters:
// feeds operand digits MSD-first, pads for the online delay and collects the result.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | arbitrate; accept one operand and clear the result register
//   FEED    | one digit step per cycle; capture dp_z once cnt >= DELAY
//   HOLD    | present result until the consumer takes it
module online_ccm_sched
    import online_ccm_sched_pkg::*;
#(
    parameter int STAGE = 4,
    parameter int DELAY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    online_ccm_sched_if.slave       bus
);

    localparam int OUT_DIGITS = STAGE + 2;
    localparam int OP_W       = sd_bits(STAGE);
    localparam int RES_W      = sd_bits(OUT_DIGITS);
    localparam int STEPS      = DELAY + OUT_DIGITS;
    localparam int CNT_W      = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] STAGE_CNT = CNT_W'(STAGE);

    sched_state_t       state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [OP_W-1:0]    opnd;
    logic [RES_W-1:0]   res_data_q;
    logic               res_id_q;
    logic               grant;
    logic               accept0, accept1, accept;

    online_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        accept0 = (state == ST_IDLE) && !grant && bus.req0_valid;
        accept1 = (state == ST_IDLE) &&  grant && bus.req1_valid;
        accept  = accept0 || accept1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.dp_en      = 1'b0;
        bus.dp_first   = 1'b0;
        bus.dp_x       = SD_ZERO;
        bus.res_valid  = 1'b0;
        bus.res_data   = res_data_q;
        bus.res_id     = res_id_q;
        case (state)
            ST_IDLE: begin
                bus.req0_ready = accept0;
                bus.req1_ready = accept1;
                if (accept) begin
                    state_nxt = ST_FEED;
                end
            end
            ST_FEED: begin
                bus.dp_en    = 1'b1;
                bus.dp_first = (cnt == '0);
                if (cnt < STAGE_CNT) begin
                    bus.dp_x = opnd[OP_W-1 -: 2];
                end
                if (cnt == LAST_CNT) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand shifter, step counter and result collector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            opnd       <= '0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else if (accept) begin
            cnt        <= '0;
            opnd       <= grant ? bus.req1_data : bus.req0_data;
            res_data_q <= '0;
            res_id_q   <= grant;
        end else if (state == ST_FEED) begin
            opnd <= {opnd[OP_W-3:0], SD_ZERO};
            if (cnt != LAST_CNT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (cnt >= DELAY_CNT) begin
                res_data_q <= {res_data_q[RES_W-3:0], bus.dp_z};
            end
        end
    end

endmodule

// File: tb/tb_online_ccm_sched.sv
// Self-checking bench for online_ccm_sched with a delay-line stub datapath.
// Results are predicted at the handshake and compared when the DUT presents them.
module tb_online_ccm_sched;

    localparam int STAGE = 4;
    localparam int DELAY = 2;

    typedef struct {
        logic        v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic        exp_id;
        logic [11:0] exp_res;
    } vec_t;

    typedef struct {
        logic        id;
        logic [11:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   hs_cnt [2];
    logic model_last = 1'b1;
    sb_t  sb_q [$];
    vec_t vecs [6];
    logic [1:0] pipe [DELAY];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    online_ccm_sched_if #(.STAGE(STAGE)) bus ();

    online_ccm_sched #(.STAGE(STAGE), .DELAY(DELAY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stub datapath: dp_z is dp_x delayed DELAY enabled cycles, cleared on dp_first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) pipe[i] <= 2'b00;
        end else if (bus.dp_en) begin
            pipe[0] <= bus.dp_x;
            for (int i = 1; i < DELAY; i++) pipe[i] <= bus.dp_first ? 2'b00 : pipe[i-1];
        end
    end
    assign bus.dp_z = pipe[DELAY-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: round-robin model, scoreboard push on handshake, pop on result.
    always begin
        logic       id;
        logic       exp_g;
        sb_t        ent;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            sb_q.delete();
            model_last = 1'b1;
        end else begin
            if (bus.req0_ready || bus.req1_ready) begin
                id = bus.req1_ready;
                chk("single_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
                exp_g = (bus.req0_valid && bus.req1_valid) ? ~model_last : bus.req1_valid;
                chk("rr_grant", {31'd0, id}, {31'd0, exp_g});
                model_last = id;
                ent.id   = id;
                ent.data = {(id ? bus.req1_data : bus.req0_data), 4'b0000};
                sb_q.push_back(ent);
                hs_cnt[id]++;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: actual=result id %0d expected=no result", bus.res_id);
                end else begin
                    ent = sb_q.pop_front();
                    chk("sb_res_id", {31'd0, bus.res_id}, {31'd0, ent.id});
                    chk("sb_res_data", {20'd0, bus.res_data}, {20'd0, ent.data});
                end
            end
        end
    end

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: actual=timeout expected=finish");
        summary();
        $finish;
    end

    // Returns at negedge+1 of the cycle in which a ready is seen.
    task automatic wait_hs(output int id, output bit ok);
        ok = 1'b0;
        id = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                id = bus.req1_ready ? 1 : 0;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (bus.res_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_dp_en", {31'd0, bus.dp_en}, 32'd0);
        chk("rst_dp_first", {31'd0, bus.dp_first}, 32'd0);
        chk("rst_dp_x", {30'd0, bus.dp_x}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_data", {20'd0, bus.res_data}, 32'd0);
        chk("rst_res_id", {31'd0, bus.res_id}, 32'd0);
    endtask

    // Checks the 8 FEED cycles following a handshake; optionally drops both valids.
    task automatic check_feed(input logic [7:0] op, input bit drop);
        logic [7:0] tmp;
        logic [1:0] exp_x;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0 && drop) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            #1;
            tmp   = op << (2 * k);
            exp_x = (k < STAGE) ? tmp[7:6] : 2'b00;
            chk("feed_dp_en", {31'd0, bus.dp_en}, 32'd1);
            chk("feed_dp_first", {31'd0, bus.dp_first}, (k == 0) ? 32'd1 : 32'd0);
            chk("feed_dp_x", {30'd0, bus.dp_x}, {30'd0, exp_x});
            chk("feed_res_valid", {31'd0, bus.res_valid}, 32'd0);
        end
    endtask

    initial begin
        int id;
        int t0;
        int tprev;
        int nhs;
        int nfirst;
        int h1;
        bit ok;

        hs_cnt[0] = 0;
        hs_cnt[1] = 0;
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        bus.res_ready  = 1'b1;

        vecs[0] = '{1'b1, 8'b10_01_00_10, 1'b0, 8'h00, 1'b0, 12'b10_01_00_10_00_00};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 12'h550};
        vecs[2] = '{1'b1, 8'hAA, 1'b1, 8'h3C, 1'b0, 12'hAA0};
        vecs[3] = '{1'b1, 8'hFF, 1'b1, 8'hC3, 1'b1, 12'hC30};
        vecs[4] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 12'h000};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h96, 1'b1, 12'h960};

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single operations.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req0_valid = vecs[i].v0;
            bus.req0_data  = vecs[i].d0;
            bus.req1_valid = vecs[i].v1;
            bus.req1_data  = vecs[i].d1;
            wait_hs(id, ok);
            chk("vec_hs_seen", {31'd0, ok}, 32'd1);
            chk("vec_grant", id, {31'd0, vecs[i].exp_id});
            check_feed(vecs[i].exp_id ? vecs[i].d1 : vecs[i].d0, 1'b1);
            @(negedge clk);
            #1;
            chk("vec_res_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("vec_res_id", {31'd0, bus.res_id}, {31'd0, vecs[i].exp_id});
            chk("vec_res_data", {20'd0, bus.res_data}, {20'd0, vecs[i].exp_res});
        end

        // Both valid straight out of reset: req0 first, req1 ten cycles later.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hAA;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h55;
        wait_hs(id, ok);
        chk("both_first_seen", {31'd0, ok}, 32'd1);
        chk("both_first_id", id, 32'd0);
        t0 = cyc;
        @(negedge clk);
        wait_hs(id, ok);
        chk("both_second_seen", {31'd0, ok}, 32'd1);
        chk("both_second_id", id, 32'd1);
        chk("both_gap", cyc - t0, 32'd10);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_res(ok);
        chk("both_res_seen", {31'd0, ok}, 32'd1);

        // Stall in HOLD with req1 pending.
        @(negedge clk);
        bus.res_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h96;
        wait_hs(id, ok);
        chk("stall_hs_id", id, 32'd0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h3C;
        wait_res(ok);
        chk("stall_res_seen", {31'd0, ok}, 32'd1);
        for (int j = 0; j < 5; j++) begin
            chk("stall_res_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("stall_res_data", {20'd0, bus.res_data}, 32'h960);
            chk("stall_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
            @(negedge clk);
            if (j == 4) bus.res_ready = 1'b1;
            #1;
        end
        chk("stall_release_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("stall_release_req1", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("stall_grant_after", {31'd0, bus.req1_ready}, 32'd1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_res(ok);
        chk("stall_req1_res_seen", {31'd0, ok}, 32'd1);

        // Reset mid-FEED aborts; after release req0 wins again.
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h5A;
        wait_hs(id, ok);
        chk("abort_hs_id", id, 32'd0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("abort_pre_dp_en", {31'd0, bus.dp_en}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_dp_en", {31'd0, bus.dp_en}, 32'd0);
        chk("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("abort_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        chk("abort_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        chk("abort_res_data", {20'd0, bus.res_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h21;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h84;
        wait_hs(id, ok);
        chk("abort_after_id", id, 32'd0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_res(ok);
        chk("abort_after_res", {20'd0, bus.res_data}, 32'h210);

        // Continuous req0: 10-cycle period, one dp_first per operation.
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hE7;
        wait_hs(id, ok);
        chk("stream_first_seen", {31'd0, ok}, 32'd1);
        tprev  = cyc;
        nhs    = 0;
        nfirst = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (bus.dp_first) nfirst++;
            if (bus.req0_ready) begin
                chk("stream_gap", cyc - tprev, 32'd10);
                tprev = cyc;
                nhs++;
            end
        end
        chk("stream_hs_count", nhs, 32'd3);
        chk("stream_first_count", nfirst, 32'd3);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        wait_res(ok);
        chk("stream_last_res", {20'd0, bus.res_data}, 32'hE70);

        // req1 pulse during FEED must not be granted.
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h18;
        wait_hs(id, ok);
        h1 = hs_cnt[1];
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'hFF;
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_res(ok);
        chk("pulse_res_data", {20'd0, bus.res_data}, 32'h180);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("pulse_idle_dp_en", {31'd0, bus.dp_en}, 32'd0);
            chk("pulse_idle_res_valid", {31'd0, bus.res_valid}, 32'd0);
        end
        chk("pulse_no_req1_grant", hs_cnt[1], h1);
        chk("sb_drained", sb_q.size(), 32'd0);

        summary();
        $finish;
    end

endmodule

// File: doc/online_ccm_sched.md
Name: online_ccm_sched

Overview:
- Sequencer and round-robin arbiter that shares one digit-serial online multiply-by-3 datapath (radix-2 signed-digit, MSD-first) between two requesters.
- Accepts a parallel SD operand, feeds its digits MSD-first, pads with zero digits to cover the online delay, and collects the output digits into a parallel SD result.
- Sits between the filter-tap control logic and the shared online CCM/adder slice.

Parameters:
- STAGE, 4, digits per input operand; the operand is 2*STAGE bits, with 2 bits per SD digit encoded {plus,minus}.
- DELAY, 2, online delay of the datapath in digits: the first output digit appears DELAY enabled cycles after the first input digit.
- OUT_DIGITS, STAGE+2, localparam giving the number of result digits; the result width is 2*(STAGE+2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req0_valid  in  1  requester 0 has an operand
- req0_data  in  2*STAGE  requester 0 operand
- req0_ready  out  1  requester 0 operand accepted this cycle
- req1_valid  in  1  requester 1 has an operand
- req1_data  in  2*STAGE  requester 1 operand
- req1_ready  out  1  requester 1 operand accepted this cycle
- dp_en  out  1  datapath digit-step enable
- dp_first  out  1  first digit of an operation; datapath clears its residual
- dp_x  out  2  SD digit to the datapath
- dp_z  in  2  SD digit from the datapath
- res_valid  out  1  result available
- res_data  out  2*(STAGE+2)  result, MSD in the top bits
- res_id  out  1  requester the result belongs to
- res_ready  in  1  consumer takes the result

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset state: IDLE, cnt=0, last_grant=1. All outputs are 0; res_data=0.
- States: IDLE, FEED, HOLD.
- IDLE:
  - grant = round-robin choice among asserted req*_valid. The requester not equal to last_grant has priority; if only one is valid, it wins.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. This is combinational: exactly one cycle, at most one requester.
  - On the handshake: latch the operand into the shift register, latch res_id, set last_grant=N, cnt=0, go to FEED.
  - A requester may drop valid without a handshake; there is no lock-in.
- FEED:
  - dp_en=1 every cycle.
  - dp_first=1 only when cnt==0.
  - dp_x = operand MSD for cnt<STAGE; 2'b00 (zero digit) for cnt>=STAGE. The operand shifts left by 2 bits each cycle.
  - When cnt>=DELAY, capture dp_z: res_data <= {res_data[2*(STAGE+2)-3:0], dp_z}.
  - cnt increments each cycle. At cnt==DELAY+OUT_DIGITS-1, go to HOLD.
- HOLD:
  - res_valid=1; res_data and res_id are held stable.
  - When res_ready=1, go to IDLE.
  - No grant is issued in HOLD or FEED.
- Outside FEED: dp_en=0, dp_first=0, dp_x=2'b00.
- Timing for a handshake at cycle T:
  - FEED runs T+1 .. T+DELAY+OUT_DIGITS.
  - res_valid rises at T+DELAY+OUT_DIGITS+1.
  - With res_ready held high, the next accept is possible at T+DELAY+OUT_DIGITS+2. For defaults this is a 10-cycle period.
- Digit values pass through unmodified, including the redundant zero 2'b11.
- res_data is cleared to 0 on the handshake, so stale digits cannot leak.
- If reset is asserted mid-FEED or mid-HOLD, the operation is aborted and everything returns to reset values immediately. No result is produced.
- cnt width is clog2(DELAY+OUT_DIGITS). There is no wrap-around within an operation.

Decomposition:
- Shared include online_defs.vh holds:
  - SD digit encodings: SD_ZERO=2'b00, SD_POS=2'b10, SD_NEG=2'b01.
  - Macro for digits-to-bits width (2*n).
  - State encodings IDLE/FEED/HOLD.
- One natural sub-module: online_rr_arb2. It is the 2-way round-robin grant with a last_grant register updated on accept.
- The FSM, counter and shift registers stay in the top module.

Test Plan:
Bench stub datapath: dp_z = dp_x delayed DELAY enabled cycles, cleared on dp_first. STAGE=4, DELAY=2 throughout.
- req0_valid=1, req0_data=8'b10_01_00_10, res_ready=1 -> req0_ready at T; dp_x sequence 10,01,00,10,00,00,00,00 at T+1..T+8; res_valid at T+9 with res_data=12'b10_01_00_10_00_00 and res_id=0.
- Both valid from reset, req0_data=8'hAA, req1_data=8'h55 -> req0 is granted first (res_id=0, res_data=12'hAA0); req1 is granted next (res_id=1, res_data=12'h550). The two grants are 10 cycles apart.
- res_ready held 0 for 5 cycles in HOLD while req1_valid=1 -> res_valid and res_data are stable, req1_ready=0 throughout. The grant happens the cycle after res_ready=1.
- rst_n pulsed low at FEED cnt==3 -> dp_en, res_valid and both readies are 0 immediately. After release, with both valid, req0 is granted first.
- req0_valid held 1 continuously, req1 idle, res_ready=1 -> req0_ready pulses every 10 cycles; dp_first is high exactly once per operation.
- req1_valid pulsed for one cycle while in FEED, then dropped -> no req1_ready and no spurious operation.
